// File: rtl/updown_counter_db.sv
// Debounced push-button up/down counter with limits, wrap/saturate and load.
// Optional auto-repeat while held: define AUTO_REPEAT_EN.
module updown_counter_db #(
  parameter int WIDTH         = 4,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 2**WIDTH-1,
  parameter int DB_CYCLES     = 1000000,
  parameter bit SATURATE      = 1'b0,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_btn,
  input  logic             dec_btn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [WIDTH:0] MINV = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_VAL);

  logic [1:0]    raw;
  logic [1:0]    s1_q;
  logic [1:0]    s2_q;
  logic [1:0]    deb_q;
  logic [1:0]    deb_d;
  logic [1:0]    press;
  logic [1:0]    step;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH:0]   cur;
  logic [WIDTH:0]   ldx;

  assign raw = {dec_btn, inc_btn};

  // Index 0 is the increment button, index 1 the decrement button.
  always_comb begin
    deb_d = deb_q;
    press = 2'b00;
    for (int b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (s2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          deb_d[b] = s2_q[b];
          press[b] = s2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 2'b00;
      s2_q  <= 2'b00;
      deb_q <= 2'b00;
      for (int b = 0; b < 2; b++) cnt_q[b] <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      for (int b = 0; b < 2; b++) cnt_q[b] <= cnt_d[b];
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q [2];
  logic [RW-1:0] rep_d [2];
  logic [1:0]    rpt;

  always_comb begin
    rpt = 2'b00;
    for (int b = 0; b < 2; b++) begin
      rep_d[b] = '0;
      if (deb_q[b] && !load) begin
        if (rep_q[b] == REP_LAST) rpt[b] = 1'b1;
        else rep_d[b] = rep_q[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) rep_q[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) rep_q[b] <= rep_d[b];
    end
  end

  assign step = press | rpt;
`else
  assign step = press;
`endif

  assign cur = {1'b0, count_q};
  assign ldx = {1'b0, load_val};

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      if (ldx < MINV)      count_d = MINV[WIDTH-1:0];
      else if (ldx > MAXV) count_d = MAXV[WIDTH-1:0];
      else                 count_d = load_val;
    end else if (step == 2'b01) begin
      if (cur < MAXV) begin
        count_d = count_q + 1'b1;
      end else if (!SATURATE) begin
        count_d = MINV[WIDTH-1:0];
        wrap_d  = 1'b1;
      end
    end else if (step == 2'b10) begin
      if (cur > MINV) begin
        count_d = count_q - 1'b1;
      end else if (!SATURATE) begin
        count_d = MAXV[WIDTH-1:0];
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= MINV[WIDTH-1:0];
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign at_max = (cur == MAXV);
  assign at_min = (cur == MINV);

endmodule

// File: tb/tb_updown_counter_db.sv
// Bench for updown_counter_db: wrap and saturate instances side by side,
// directed scenarios plus random button/load traffic against a model.
module tb_updown_counter_db;

  localparam int MINV = 2;
  localparam int MAXV = 9;
  localparam int DB   = 4;
  localparam int REP  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inc_btn = 1'b0;
  logic       dec_btn = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] count_w, count_s;
  logic       at_max_w, at_min_w, wrap_w;
  logic       at_max_s, at_min_s, wrap_s;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_counter_db #(
    .WIDTH(4), .MIN_VAL(MINV), .MAX_VAL(MAXV),
    .DB_CYCLES(DB), .SATURATE(1'b0), .REPEAT_CYCLES(REP)
  ) u_wrap (
    .clk(clk), .reset(reset), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .load(load), .load_val(load_val), .count(count_w),
    .at_max(at_max_w), .at_min(at_min_w), .wrap(wrap_w)
  );

  updown_counter_db #(
    .WIDTH(4), .MIN_VAL(MINV), .MAX_VAL(MAXV),
    .DB_CYCLES(DB), .SATURATE(1'b1), .REPEAT_CYCLES(REP)
  ) u_sat (
    .clk(clk), .reset(reset), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .load(load), .load_val(load_val), .count(count_s),
    .at_max(at_max_s), .at_min(at_min_s), .wrap(wrap_s)
  );

  // Reference model. Index 0/1 of button state = inc/dec;
  // index 0/1 of mc/mw = wrap instance / saturate instance.
  int hist1 [2];
  int hist2 [2];
  int lvl   [2];
  int run   [2];
  int age   [2];
  int mc    [2];
  int mw    [2];

  task automatic model_edge(input bit i, input bit d, input bit ld,
                            input int lv, input bit r);
    int raw [2];
    int go  [2];
    int sv;
    raw[0] = i;
    raw[1] = d;
    if (r) begin
      for (int b = 0; b < 2; b++) begin
        hist1[b] = 0; hist2[b] = 0; lvl[b] = 0; run[b] = 0; age[b] = 0;
        mc[b] = MINV; mw[b] = 0;
      end
      return;
    end
    for (int b = 0; b < 2; b++) begin
      go[b] = 0;
`ifdef AUTO_REPEAT_EN
      // while held: one extra step each REP edges since the last step
      if (lvl[b] == 1 && !ld) begin
        age[b]++;
        if (age[b] == REP) begin
          go[b] = 1;
          age[b] = 0;
        end
      end else begin
        age[b] = 0;
      end
`endif
      // level seen by the debouncer is the raw sample from two edges ago
      sv = hist2[b];
      if (sv != lvl[b]) begin
        run[b]++;
        if (run[b] == DB) begin
          lvl[b] = sv;
          run[b] = 0;
          if (sv == 1) go[b] = 1;
        end
      end else begin
        run[b] = 0;
      end
      hist2[b] = hist1[b];
      hist1[b] = raw[b];
    end
    for (int k = 0; k < 2; k++) begin
      mw[k] = 0;
      if (ld) begin
        mc[k] = (lv < MINV) ? MINV : (lv > MAXV) ? MAXV : lv;
      end else if (go[0] == 1 && go[1] == 0) begin
        if (mc[k] < MAXV) mc[k]++;
        else if (k == 0) begin mc[k] = MINV; mw[k] = 1; end
      end else if (go[1] == 1 && go[0] == 0) begin
        if (mc[k] > MINV) mc[k]--;
        else if (k == 0) begin mc[k] = MAXV; mw[k] = 1; end
      end
    end
  endtask

  task automatic tick(input bit i, input bit d, input bit ld,
                      input int lv, input bit r);
    inc_btn  = i;
    dec_btn  = d;
    load     = ld;
    load_val = lv[3:0];
    reset    = r;
    @(posedge clk);
    model_edge(i, d, ld, lv, r);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic do_load(input int v);
    tick(0, 0, 1, v, 0);
  endtask

  task automatic test_reset;
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    n_checks++;
    if (count_w !== 4'd2 || at_min_w !== 1'b1 || at_max_w !== 1'b0 ||
        wrap_w !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wrap: got cnt=%0d min=%b max=%b wrap=%b need 2 1 0 0",
               count_w, at_min_w, at_max_w, wrap_w);
    end
    n_checks++;
    if (count_s !== 4'd2 || at_min_s !== 1'b1 || at_max_s !== 1'b0 ||
        wrap_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sat: got cnt=%0d min=%b max=%b wrap=%b need 2 1 0 0",
               count_s, at_min_s, at_max_s, wrap_s);
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_debounce;
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 3; k++) tick(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0);
    end
    n_checks++;
    if (count_w !== 4'd2) begin
      n_fail++;
      $display("FAIL glitch_reject: got %0d need 2", count_w);
    end
    // edge e is the (e+1)-th edge sampling the held button
    for (int e = 0; e <= 5; e++) begin
      tick(1, 0, 0, 0, 0);
      n_checks++;
      if (count_w !== ((e < 5) ? 4'd2 : 4'd3)) begin
        n_fail++;
        $display("FAIL press_latency e%0d: got %0d need %0d",
                 e, count_w, (e < 5) ? 2 : 3);
      end
    end
    idle(8);
  endtask

  task automatic test_wrap_saturate;
    do_load(9);
    n_checks++;
    if (count_w !== 4'd9 || at_max_w !== 1'b1 || count_s !== 4'd9) begin
      n_fail++;
      $display("FAIL load9: got w=%0d max=%b s=%0d need 9 1 9",
               count_w, at_max_w, count_s);
    end
    for (int e = 0; e <= 5; e++) tick(1, 0, 0, 0, 0);
    n_checks++;
    if (count_w !== 4'd2 || wrap_w !== 1'b1 || count_s !== 4'd9 ||
        wrap_s !== 1'b0) begin
      n_fail++;
      $display("FAIL inc_at_max: got w=%0d/%b s=%0d/%b need 2/1 9/0",
               count_w, wrap_w, count_s, wrap_s);
    end
    tick(1, 0, 0, 0, 0);
    n_checks++;
    if (wrap_w !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_one_cycle: got %b need 0", wrap_w);
    end
    idle(8);
    do_load(2);
    for (int e = 0; e <= 5; e++) tick(0, 1, 0, 0, 0);
    n_checks++;
    if (count_w !== 4'd9 || wrap_w !== 1'b1 || count_s !== 4'd2 ||
        at_min_s !== 1'b1 || wrap_s !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_at_min: got w=%0d/%b s=%0d/%b/%b need 9/1 2/1/0",
               count_w, wrap_w, count_s, at_min_s, wrap_s);
    end
    idle(8);
  endtask

  task automatic test_simultaneous;
    do_load(5);
    for (int e = 0; e <= 5; e++) tick(1, 1, 0, 0, 0);
    n_checks++;
    if (count_w !== 4'd5 || wrap_w !== 1'b0 || count_s !== 4'd5) begin
      n_fail++;
      $display("FAIL both_buttons: got w=%0d/%b s=%0d need 5/0 5",
               count_w, wrap_w, count_s);
    end
    idle(8);
    for (int e = 0; e < 5; e++) tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 12, 0);
    n_checks++;
    if (count_w !== 4'd9 || count_s !== 4'd9) begin
      n_fail++;
      $display("FAIL load_clamp_hi_step: got w=%0d s=%0d need 9",
               count_w, count_s);
    end
    idle(8);
    do_load(0);
    n_checks++;
    if (count_w !== 4'd2 || count_s !== 4'd2) begin
      n_fail++;
      $display("FAIL load_clamp_lo: got w=%0d s=%0d need 2", count_w, count_s);
    end
  endtask

  task automatic test_reset_mid;
    int steps;
    for (int k = 0; k < 3; k++) tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1);
    n_checks++;
    if (count_w !== 4'd2 || at_min_w !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got %0d min=%b need 2 1", count_w, at_min_w);
    end
    steps = 0;
    for (int e = 0; e <= 8; e++) begin
      tick(1, 0, 0, 0, 0);
      n_checks++;
      if (count_w !== ((e < 5) ? 4'd2 : 4'd3)) begin
        n_fail++;
        $display("FAIL reset_relatch e%0d: got %0d need %0d",
                 e, count_w, (e < 5) ? 2 : 3);
      end
    end
    idle(8);
  endtask

  task automatic test_auto_repeat;
    int want;
`ifdef AUTO_REPEAT_EN
    want = 6;
`else
    want = 3;
`endif
    do_load(2);
    for (int e = 0; e <= 5; e++) tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 35; k++) tick(1, 0, 0, 0, 0);
    n_checks++;
    if (count_w !== want[3:0] || count_s !== want[3:0]) begin
      n_fail++;
      $display("FAIL hold_repeat: got w=%0d s=%0d need %0d",
               count_w, count_s, want);
    end
    idle(8);
  endtask

  task automatic test_random;
    int lvl_in [2];
    int left   [2];
    bit ld, r;
    int lv;
    int obs_c, obs_w, obs_mx, obs_mn;
    lvl_in[0] = 0; lvl_in[1] = 0;
    left[0] = 0;   left[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (left[b] == 0) begin
          lvl_in[b] = $urandom_range(0, 1);
          left[b]   = $urandom_range(1, 16);
        end
        left[b]--;
      end
      ld = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 299) == 0);
      lv = $urandom_range(0, 15);
      tick(lvl_in[0][0], lvl_in[1][0], ld, lv, r);
      for (int k = 0; k < 2; k++) begin
        obs_c  = (k == 0) ? int'(count_w) : int'(count_s);
        obs_w  = (k == 0) ? int'(wrap_w) : int'(wrap_s);
        obs_mx = (k == 0) ? int'(at_max_w) : int'(at_max_s);
        obs_mn = (k == 0) ? int'(at_min_w) : int'(at_min_s);
        n_checks++;
        if (obs_c != mc[k] || obs_w != mw[k] ||
            obs_mx != int'(mc[k] == MAXV) || obs_mn != int'(mc[k] == MINV)) begin
          n_fail++;
          $display("FAIL random c%0d inst%0d: got cnt=%0d wrap=%0d max=%0d min=%0d need %0d %0d %0d %0d",
                   c, k, obs_c, obs_w, obs_mx, obs_mn,
                   mc[k], mw[k], int'(mc[k] == MAXV), int'(mc[k] == MINV));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_wrap_saturate();
    test_simultaneous();
    test_reset_mid();
    test_auto_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
